// File: rtl/week04_first02_pkg.sv
// Shared constants for the week-4 clock-enabled D register.
// Width bounds and the default reset pattern live here so every instance agrees.
package week04_first02_pkg;

  localparam int WIDTH_MAX = 64;

  localparam logic [WIDTH_MAX-1:0] RESET_VALUE_DEFAULT = '0;

endpackage : week04_first02_pkg

// File: rtl/week04_first02.sv
// D-type register with clock enable and synchronous active-high reset.
// Reset has priority over enable; Qout comes straight from the flops.
module week04_first02
  import week04_first02_pkg::*;
#(
  parameter int                WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = RESET_VALUE_DEFAULT[WIDTH-1:0]
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ce,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Qout
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("week04_first02: WIDTH out of legal range 1..WIDTH_MAX");
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Qout <= RESET_VALUE;
    end else if (Ce) begin
      Qout <= Din;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only: once a reset edge has been seen, Qout must never be X/Z.
  logic reset_seen;

  always_ff @(posedge CLK) begin
    if (RST) begin
      reset_seen <= 1'b1;
    end
  end

  a_qout_known_after_reset : assert property (
    @(posedge CLK) (reset_seen === 1'b1) |-> !$isunknown(Qout)
  );
`endif

endmodule : week04_first02

// File: tb/tb_week04_first02.sv
// Self-checking bench for week04_first02: a 1-bit and an 8-bit instance share
// RST/Ce; table vectors and a random run feed a scoreboard checked each cycle.
module tb_week04_first02;

  localparam logic [7:0] RV8 = 8'h3C;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       din1;
  logic [7:0] din8;
  logic       q1;
  logic [7:0] q8;

  int n_compared   = 0;
  int n_mismatched = 0;

  week04_first02 dut1 (
    .CLK  (clk),
    .RST  (rst),
    .Ce   (ce),
    .Din  (din1),
    .Qout (q1)
  );

  week04_first02 #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .CLK  (clk),
    .RST  (rst),
    .Ce   (ce),
    .Din  (din8),
    .Qout (q8)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ce;
    logic       d1;
    logic [7:0] d8;
    logic       e1;
    logic [7:0] e8;
  } vec_t;

  typedef struct {
    logic       e1;
    logic [7:0] e8;
  } exp_t;

  exp_t       sb[$];
  logic       have_prev = 1'b0;
  logic       prev1;
  logic [7:0] prev8;

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive on the falling edge, confirm nothing leaks through before the rising
  // edge, then compare the scoreboard head on the next falling edge.
  task automatic step(input logic r, input logic c, input logic d1,
                      input logic [7:0] d8, input logic e1, input logic [7:0] e8,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst  = r;
    ce   = c;
    din1 = d1;
    din8 = d8;
    sb.push_back('{e1: e1, e8: e8});
    #20;
    if (have_prev) begin
      check({name, "/pre_edge_q1"}, {7'b0, q1}, {7'b0, prev1});
      check({name, "/pre_edge_q8"}, q8, prev8);
    end
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s/scoreboard: queue empty, expected an entry", name);
    end else begin
      e = sb.pop_front();
      check({name, "/q1"}, {7'b0, q1}, {7'b0, e.e1});
      check({name, "/q8"}, q8, e.e8);
      prev1     = e.e1;
      prev8     = e.e8;
      have_prev = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic       m1;
    logic [7:0] m8;

    rst  = 1'b0;
    ce   = 1'b0;
    din1 = 1'b0;
    din8 = 8'h00;
    repeat (2) @(negedge clk);

    //          rst   ce    d1    d8     e1    e8
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, RV8  }); // reset beats Ce/Din
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, RV8  }); // stays reset value
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, RV8  }); // hold, Din toggles
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, RV8  });
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h22, 1'b0, RV8  });
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5}); // capture
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 8'hA5}); // hold captured value
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A}); // capture zero
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, RV8  }); // priority
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5}); // pulse enable
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 8'h81});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, RV8  }); // reset with Ce low
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].d1, vecs[i].d8,
           vecs[i].e1, vecs[i].e8, $sformatf("vec%0d", i));
    end

    m1 = 1'b1;
    m8 = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      logic       r;
      logic       c;
      logic       d1;
      logic [7:0] d8;
      r  = ($urandom_range(0, 7) == 0);
      c  = $urandom_range(0, 1) == 1;
      d1 = $urandom_range(0, 1) == 1;
      d8 = 8'($urandom_range(0, 255));
      if (r) begin
        m1 = 1'b0;
        m8 = RV8;
      end else if (c) begin
        m1 = d1;
        m8 = d8;
      end
      step(r, c, d1, d8, m1, m8, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_week04_first02
